// File: rtl/l_gates_bist_ctrl.sv
// rtl/l_gates_bist_ctrl.sv - BIST sequencer for the 7-output two-input logic-gate block
module l_gates_bist_ctrl #(
  parameter int SETTLE_CYCLES = 2,
  parameter bit HOLD_LAST     = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] gate_y,
  output logic       gate_a,
  output logic       gate_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [6:0] fail_mask,
  output logic [2:0] err_count,
  output logic [1:0] vec_idx
);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [3:0] settle_cnt;
  logic [6:0] mismatch;

  // Bit order of the gate block: and, or, nand, nor, xor, xnor, not-a.
  function automatic logic [6:0] golden(input logic [1:0] v);
    logic a;
    logic b;
    a = v[1];
    b = v[0];
    golden = {~a, ~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b};
  endfunction

  assign mismatch = gate_y ^ golden(vec_idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      settle_cnt <= 4'd0;
      gate_a     <= 1'b0;
      gate_b     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_mask  <= 7'd0;
      err_count  <= 3'd0;
      vec_idx    <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= SETTLE;
            vec_idx    <= 2'd0;
            gate_a     <= 1'b0;
            gate_b     <= 1'b0;
            settle_cnt <= RELOAD;
            fail_mask  <= 7'd0;
            err_count  <= 3'd0;
            pass       <= 1'b0;
            busy       <= 1'b1;
          end
        end
        SETTLE: begin
          if (settle_cnt != 4'd0) begin
            settle_cnt <= settle_cnt - 4'd1;
          end else begin
            state <= CHECK;
          end
        end
        CHECK: begin
          fail_mask <= fail_mask | mismatch;
          if ((|mismatch) && (err_count != 3'd4)) begin
            err_count <= err_count + 3'd1;
          end
          if (vec_idx != 2'd3) begin
            vec_idx           <= vec_idx + 2'd1;
            {gate_a, gate_b}  <= vec_idx + 2'd1;
            settle_cnt        <= RELOAD;
            state             <= SETTLE;
          end else begin
            // Fold in the last compare directly; fail_mask is not updated yet.
            pass  <= ((fail_mask | mismatch) == 7'd0);
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
          if (!HOLD_LAST) begin
            gate_a  <= 1'b0;
            gate_b  <= 1'b0;
            vec_idx <= 2'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l_gates_bist_ctrl.sv
// tb/tb_l_gates_bist_ctrl.sv - self-checking bench for l_gates_bist_ctrl
module tb_l_gates_bist_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start [2];
  logic [6:0] gy [2];
  logic       ga [2];
  logic       gb [2];
  logic       busy [2];
  logic       done [2];
  logic       pass [2];
  logic [6:0] fm [2];
  logic [2:0] ec [2];
  logic [1:0] vi [2];
  logic [6:0] inj [2][4];
  logic [1:0] prev_ab [2];
  logic       glitch_en;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_gold(input logic a, input logic b);
    logic [6:0] y;
    y[0] = a & b;
    y[1] = a | b;
    y[2] = !(a & b);
    y[3] = !(a | b);
    y[4] = a ^ b;
    y[5] = !(a ^ b);
    y[6] = !a;
    return y;
  endfunction

  // Faulty gate model: per-vector error mask, plus a full-width glitch in the
  // first cycle after the inputs change (never a compare cycle).
  function automatic logic [6:0] gate_model(input logic a, input logic b, input logic [6:0] e,
                                            input logic [1:0] pab, input logic gl);
    return ref_gold(a, b) ^ e ^ ((gl && ({a, b} != pab)) ? 7'h7f : 7'h00);
  endfunction

  assign gy[0] = gate_model(ga[0], gb[0], inj[0][{ga[0], gb[0]}], prev_ab[0], glitch_en);
  assign gy[1] = gate_model(ga[1], gb[1], inj[1][{ga[1], gb[1]}], prev_ab[1], glitch_en);

  always @(posedge clk) begin
    prev_ab[0] <= {ga[0], gb[0]};
    prev_ab[1] <= {ga[1], gb[1]};
  end

  l_gates_bist_ctrl #(.SETTLE_CYCLES(2), .HOLD_LAST(1'b1)) dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .gate_y(gy[0]), .gate_a(ga[0]), .gate_b(gb[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .fail_mask(fm[0]), .err_count(ec[0]),
    .vec_idx(vi[0]));

  l_gates_bist_ctrl #(.SETTLE_CYCLES(1), .HOLD_LAST(1'b0)) dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .gate_y(gy[1]), .gate_a(ga[1]), .gate_b(gb[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .fail_mask(fm[1]), .err_count(ec[1]),
    .vec_idx(vi[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input int d, input string nm);
    chk({nm, " busy"}, 32'(busy[d]), 0);
    chk({nm, " done"}, 32'(done[d]), 0);
    chk({nm, " pass"}, 32'(pass[d]), 0);
    chk({nm, " fail_mask"}, 32'(fm[d]), 0);
    chk({nm, " err_count"}, 32'(ec[d]), 0);
    chk({nm, " gate_ab"}, 32'({ga[d], gb[d]}), 0);
    chk({nm, " vec_idx"}, 32'(vi[d]), 0);
  endtask

  // Called at a negedge; start is sampled at the next rising edge (E0).
  // flags[0]: extra starts at edges 3 and 7; flags[1]: start during the DONE cycle.
  task automatic run(input int d, input logic exp_pass, input logic [6:0] exp_fm,
                     input logic [2:0] exp_ec, input logic [1:0] flags);
    int sc;
    int total;
    int cnt;
    sc    = (d == 0) ? 2 : 1;
    total = 4 * (sc + 1);
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    cnt = 0;
    chk("accept busy", 32'(busy[d]), 1);
    chk("accept cleared", 32'({pass[d], fm[d], ec[d]}), 0);
    while (!done[d] && cnt < 40) begin
      if (cnt < total) begin
        chk("vec_idx", 32'(vi[d]), 32'(cnt / (sc + 1)));
        chk("gate_ab", 32'({ga[d], gb[d]}), 32'(cnt / (sc + 1)));
      end
      if (flags[0]) start[d] = (cnt == 2 || cnt == 6);
      @(negedge clk);
      start[d] = 1'b0;
      cnt++;
    end
    chk("done latency", 32'(cnt), 32'(total));
    chk("done busy", 32'(busy[d]), 1);
    chk("pass", 32'(pass[d]), 32'(exp_pass));
    chk("fail_mask", 32'(fm[d]), 32'(exp_fm));
    chk("err_count", 32'(ec[d]), 32'(exp_ec));
    if (flags[1]) start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    chk("idle done", 32'(done[d]), 0);
    chk("idle busy", 32'(busy[d]), 0);
    chk("idle gate_ab", 32'({ga[d], gb[d]}), (d == 0) ? 32'd3 : 32'd0);
    chk("held fail_mask", 32'(fm[d]), 32'(exp_fm));
    chk("held pass", 32'(pass[d]), 32'(exp_pass));
    if (flags[1]) begin
      @(negedge clk);
      chk("start in DONE ignored", 32'(busy[d]), 0);
    end
  endtask

  typedef struct {
    int         d;
    logic [27:0] inj;
    logic       exp_pass;
    logic [6:0] exp_fm;
    logic [2:0] exp_ec;
  } vec_t;

  initial begin
    vec_t tbl [5];
    int   cyc;
    int   n_done;
    logic [6:0] e_fm;
    logic [2:0] e_ec;

    tbl[0] = '{0, 28'h0, 1'b1, 7'h00, 3'd0};
    tbl[1] = '{0, {7'h00, 7'h10, 7'h10, 7'h00}, 1'b0, 7'h10, 3'd2};
    tbl[2] = '{0, {7'h40, 7'h40, 7'h40, 7'h40}, 1'b0, 7'h40, 3'd4};
    tbl[3] = '{1, 28'h0, 1'b1, 7'h00, 3'd0};
    tbl[4] = '{1, {7'h01, 7'h00, 7'h00, 7'h06}, 1'b0, 7'h07, 3'd2};

    glitch_en = 1'b0;
    start[0] = 1'b0;
    start[1] = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int v = 0; v < 4; v++) inj[d][v] = 7'h00;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_zero(0, "reset0");
    chk_zero(1, "reset1");

    for (int i = 0; i < 5; i++) begin
      for (int v = 0; v < 4; v++) inj[tbl[i].d][v] = tbl[i].inj[v*7 +: 7];
      run(tbl[i].d, tbl[i].exp_pass, tbl[i].exp_fm, tbl[i].exp_ec, 2'b00);
      @(negedge clk);
    end

    // Extra starts mid-run, then start in DONE, then back-to-back start.
    for (int v = 0; v < 4; v++) inj[0][v] = 7'h00;
    run(0, 1'b1, 7'h00, 3'd0, 2'b01);
    inj[0][3] = 7'h20;
    run(0, 1'b0, 7'h20, 3'd1, 2'b10);
    inj[0][3] = 7'h00;
    run(0, 1'b1, 7'h00, 3'd0, 2'b00);

    // start and rst at the same edge: rst wins.
    start[0] = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    rst = 1'b0;
    chk_zero(0, "rst+start");

    // Reset mid-run at vector 2: no done pulse, then a clean run.
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    cyc = 0;
    while (vi[0] != 2'd2 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("reach vec2", 32'(vi[0]), 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_zero(0, "midrun rst");
    n_done = 0;
    repeat (20) begin
      @(negedge clk);
      if (done[0]) n_done++;
    end
    chk("no done after rst", 32'(n_done), 0);
    run(0, 1'b1, 7'h00, 3'd0, 2'b00);

    // Randomized error injection with settle-time glitches.
    glitch_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      int d;
      d = i % 2;
      e_fm = 7'h00;
      e_ec = 3'd0;
      for (int v = 0; v < 4; v++) begin
        inj[d][v] = ($urandom_range(1) == 0) ? 7'h00 : 7'($urandom);
        e_fm |= inj[d][v];
        if (inj[d][v] != 7'h00) e_ec++;
      end
      run(d, (e_fm == 7'h00), e_fm, e_ec, 2'($urandom_range(3)));
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/l_gates_bist_ctrl.md
Name: l_gates_bist_ctrl

Overview:
- Built-in self-test sequencer for the 7-output two-input logic-gate block (inputs a, b; output y[6:0]).
- On a start pulse it drives all four input vectors in order, waits a programmable settle time, compares y against an internally computed golden value, and reports a pass/fail result with a per-gate failure mask.
- It sits between the top-level test/debug control and one gate-block instance. It owns that instance's a/b inputs while busy.

Parameters:
- SETTLE_CYCLES, 2, cycles each vector is held before y is compared; legal range 1..15.
- HOLD_LAST, 1, 1 = keep last vector (1,1) on gate_a/gate_b after completion; 0 = return to (0,0).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  one-cycle request to run the sequence; sampled only in IDLE.
- gate_y  input  7  y output of the gate block under test.
- gate_a  output  1  drives gate block input a.
- gate_b  output  1  drives gate block input b.
- busy  output  1  high from the cycle after start is accepted until DONE is left.
- done  output  1  one-cycle pulse when the sequence completes.
- pass  output  1  1 = all 4 vectors matched; valid when done=1; held until next accepted start.
- fail_mask  output  7  OR of (gate_y XOR expected) over all checked vectors; held until next start.
- err_count  output  3  number of vectors with any mismatch (0..4); held until next start.
- vec_idx  output  2  index of vector currently applied; {gate_a,gate_b} = vec_idx while busy.

Behaviour:
- Golden map, fixed bit order:
  - y[0]=a&b
  - y[1]=a|b
  - y[2]=~(a&b)
  - y[3]=~(a|b)
  - y[4]=a^b
  - y[5]=~(a^b)
  - y[6]=~a
- Vector order: idx 0..3 = (a,b) (0,0),(0,1),(1,0),(1,1); gate_a=idx[1], gate_b=idx[0].
- States: IDLE, SETTLE, CHECK, DONE.
- Reset (rst=1 at a rising edge), from any state, mid-run included:
  - state=IDLE, all outputs 0, including gate_a/gate_b, pass, fail_mask and err_count.
  - The interrupted run produces no done pulse.
- IDLE:
  - start=1 at edge E0 -> SETTLE.
  - vec_idx=0, settle counter=SETTLE_CYCLES-1, fail_mask=0, err_count=0, pass=0, busy=1.
- SETTLE:
  - Counter nonzero -> decrement and stay.
  - Counter zero -> CHECK.
  - gate_a/gate_b stable throughout.
- CHECK (1 cycle), compare gate_y with golden(vec_idx):
  - fail_mask |= mismatch bits.
  - err_count += 1 if any mismatch (saturates at 4; cannot exceed).
  - vec_idx<3 -> vec_idx+1, counter reload, SETTLE.
  - vec_idx=3 -> DONE.
- DONE (1 cycle):
  - done=1.
  - pass = (fail_mask==0), including the vec 3 compare.
  - busy=1 in this cycle.
  - Next edge -> IDLE: busy=0, done=0; gate_a/gate_b per HOLD_LAST; results held.
- Timing:
  - Each vector occupies SETTLE_CYCLES+1 cycles.
  - done is high in the cycle following edge E0 + 4*(SETTLE_CYCLES+1); that is 12 edges after E0 at the default.
- Boundary conditions:
  - start while busy (SETTLE/CHECK/DONE): ignored, no effect on the run in progress.
  - start in the same cycle the block returns to IDLE: accepted on the following edge only (not counted in DONE).
  - start and rst at the same edge: rst wins.
  - gate_y is sampled only in CHECK; glitches during SETTLE have no effect.
  - Back-to-back runs: start at the edge after DONE->IDLE is accepted; results are cleared at that acceptance.

Test Plan:
- Correct gate model connected, SETTLE_CYCLES=2, start pulse at edge 0:
  - vec_idx steps 0,1,2,3, each held 3 cycles.
  - done=1 exactly once, 12 edges after start.
  - pass=1, fail_mask=7'h00, err_count=0.
- Gate model with y[4] stuck-at-0: fail_mask=7'b0010000, err_count=2 (vectors 1 and 2), pass=0.
- Gate model with y[6] inverted: fail_mask=7'b1000000, err_count=4, pass=0.
- Reset mid-run:
  - rst pulse while vec_idx=2 -> next cycle all outputs 0, state IDLE, no done pulse.
  - A following start runs a full clean sequence.
- Extra starts:
  - start pulses at edges 3 and 7 during a run -> ignored; single done at edge 12.
  - start at the first IDLE cycle after done -> second run begins, previous results cleared at acceptance.
- SETTLE_CYCLES=1, HOLD_LAST=0:
  - done 8 edges after start.
  - gate_a/gate_b = 0/0 after returning to IDLE.
  - Compare occurs 1 cycle after each vector change.
